// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions for the memory stage: access-size codes, writeback
// selects, MEM FSM encoding and the load/alignment helpers.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RW_ALU = 2'b00;
  localparam logic [1:0] RW_PC4 = 2'b01;
  localparam logic [1:0] RW_IMM = 2'b10;
  localparam logic [1:0] RW_BR  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } mem_state_e;

  // Unsigned size codes have no store form, so a store carrying one is a fault.
  function automatic logic access_misaligned(input logic [2:0] f3,
                                             input logic [1:0] off,
                                             input logic       is_store);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] res;
    shifted  = word >> {off, 3'b000};
    byte_val = shifted[7:0];
    half_val = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    res = {{24{byte_val[7]}}, byte_val};
      F3_H:    res = {{16{half_val[15]}}, half_val};
      F3_BU:   res = {24'h000000, byte_val};
      F3_HU:   res = {16'h0000, half_val};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// Byte-enable data RAM: one independent byte-wide array per lane, registered
// read, contents never reset.
module data_ram #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          lane_mem[addr] <= wdata[8*gi +: 8];
        end
        rd_byte_reg <= lane_mem[addr];
      end

      assign rdata[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store lane steering, two-state load FSM that
// stalls upstream for the RAM read latency, and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwrite,
  input  logic        memtoreg,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  rwsel,
  input  logic [31:0] aluresult,
  input  logic [31:0] bmux_result,
  input  logic [31:0] pc_four,
  input  logic [31:0] immg,
  input  logic [31:0] brimm,
  input  logic [4:0]  rd,
  input  logic [2:0]  f3,
  output logic        stall,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_state_e  state_reg, state_next;

  // Load context held across the LOAD cycle while upstream is stalled.
  logic [2:0]  ld_f3_reg;
  logic [4:0]  ld_rd_reg;
  logic        ld_regwrite_reg;
  logic        ld_memtoreg_reg;
  logic [31:0] ld_addr_reg;
  logic        capture;

  logic        wb_regwrite_next;
  logic [4:0]  wb_rd_next;
  logic [31:0] wb_data_next;
  logic        misaligned_next;

  logic        is_store;
  logic        access_fault;
  logic [31:0] alu_wb;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_rdata;

  assign is_store     = memwrite & ~memread;
  assign access_fault = (memread | memwrite) &
                        access_misaligned(f3, aluresult[1:0], is_store);
  assign ram_addr     = (state_reg == LOAD) ? ld_addr_reg[AW+1:2] : aluresult[AW+1:2];

  always_comb begin
    alu_wb = aluresult;
    if (!memtoreg) begin
      case (rwsel)
        RW_ALU:  alu_wb = aluresult;
        RW_PC4:  alu_wb = pc_four;
        RW_IMM:  alu_wb = immg;
        RW_BR:   alu_wb = brimm;
        default: alu_wb = aluresult;
      endcase
    end
  end

  always_comb begin
    state_next       = state_reg;
    stall            = 1'b0;
    capture          = 1'b0;
    ram_we           = 4'b0000;
    ram_wdata        = bmux_result;
    wb_regwrite_next = 1'b0;
    wb_rd_next       = wb_rd;
    wb_data_next     = wb_data;
    misaligned_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (memread) begin
          if (access_fault) begin
            misaligned_next = 1'b1;
          end else begin
            stall      = 1'b1;
            capture    = 1'b1;
            state_next = LOAD;
          end
        end else if (memwrite && access_fault) begin
          misaligned_next = 1'b1;
        end else begin
          wb_regwrite_next = regwrite;
          wb_rd_next       = rd;
          wb_data_next     = alu_wb;
          if (memwrite) begin
            case (f3)
              F3_B: begin
                ram_we    = 4'b0001 << aluresult[1:0];
                ram_wdata = {4{bmux_result[7:0]}};
              end
              F3_H: begin
                ram_we    = aluresult[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{bmux_result[15:0]}};
              end
              default: begin
                ram_we    = 4'b1111;
                ram_wdata = bmux_result;
              end
            endcase
          end
        end
      end
      LOAD: begin
        wb_regwrite_next = ld_regwrite_reg;
        wb_rd_next       = ld_rd_reg;
        wb_data_next     = ld_memtoreg_reg ?
                           load_extract(ld_f3_reg, ld_addr_reg[1:0], ram_rdata) :
                           ld_addr_reg;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Reset overrides everything visible: no stall, no RAM write.
    if (!reset) begin
      stall      = 1'b0;
      ram_we     = 4'b0000;
      capture    = 1'b0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      wb_regwrite <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
      misaligned  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wb_regwrite <= wb_regwrite_next;
      wb_rd       <= wb_rd_next;
      wb_data     <= wb_data_next;
      misaligned  <= misaligned_next;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      ld_f3_reg       <= f3;
      ld_rd_reg       <= rd;
      ld_regwrite_reg <= regwrite;
      ld_memtoreg_reg <= memtoreg;
      ld_addr_reg     <= aluresult;
    end
  end

  data_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_data_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL take parameter: DEPTH_WORDS, 256, number of 32-bit words in the data RAM; the word index is aluresult[log2(DEPTH_WORDS)+1:2].
REQ-002 SHALL have one clock; reset is synchronous and active-low. Ports are clk and reset, as elsewhere in the codebase.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-low reset.
REQ-005 regwrite, memtoreg, memread, memwrite  input  1 each  control fields from the EX/MEM register.
REQ-006 rwsel  input  2  writeback select.
REQ-007 aluresult  input  32  byte address or ALU value.
REQ-008 bmux_result  input  32  store data.
REQ-009 pc_four, immg, brimm  input  32 each  writeback candidates.
REQ-010 rd  input  5  destination register.
REQ-011 f3  input  3  access size and sign.
REQ-012 stall  output  1  hold request to the upstream stages.
REQ-013 wb_regwrite  output  1  registered register-file write enable.
REQ-014 wb_rd  output  5  registered destination register.
REQ-015 wb_data  output  32  registered writeback data.
REQ-016 misaligned  output  1  registered one-cycle access-fault pulse.

Function
REQ-017 SHALL decode f3 as follows: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. Any other code on a memory access SHALL be treated as misaligned.
REQ-018 SHALL flag an access as misaligned when it is a halfword with address[0]=1 or a word with address[1:0]!=0.
REQ-019 Stores SHALL write on the rising edge while memwrite=1 and stall=0, and SHALL update only the addressed byte lanes (SB: 1 lane, SH: 2 lanes, SW: 4 lanes) with data taken from the low bits of bmux_result.
REQ-020 A misaligned store SHALL NOT modify the RAM. It SHALL set misaligned=1 for one cycle and force wb_regwrite=0.
REQ-021 The RAM SHALL read synchronously with one cycle of latency, and its contents SHALL NOT be cleared by reset.
REQ-022 The FSM SHALL have two states, IDLE and LOAD.
- In IDLE with memread=1 and an aligned access: stall=1 (combinational), the word index is captured, the next state is LOAD, and the edge writes a bubble (wb_regwrite=0).
- In LOAD: stall=0, the edge writes the extracted load result to wb_*, and the next state is IDLE.
REQ-023 Load extraction SHALL select the byte or halfword lane by address[1:0] and then sign-extend (LB, LH) or zero-extend (LBU, LHU).
REQ-024 A misaligned load SHALL NOT stall. It SHALL give wb_regwrite=0 and misaligned=1, and the next state SHALL be IDLE.
REQ-025 For non-load cycles, wb_data SHALL be selected by rwsel: 00 aluresult, 01 pc_four, 10 immg, 11 brimm. Latency SHALL be one edge, and wb_regwrite SHALL equal regwrite.
REQ-026 memtoreg=1 SHALL select load data in the LOAD state. memtoreg=1 without memread SHALL select aluresult.
REQ-027 memread=1 together with memwrite=1 SHALL be handled as a load, with the write suppressed.
REQ-028 Upstream SHALL hold its inputs stable while stall=1. This block SHALL sample the inputs only in IDLE, using the latched values during LOAD.
REQ-029 Address bits above the word index SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-030 When wb_rd=0, wb_regwrite SHALL still propagate; suppressing writes to x0 is the register file's duty.

Reset
REQ-031 With reset=0 at an edge: state=IDLE and wb_regwrite=0, wb_rd=0, wb_data=0, misaligned=0. stall SHALL be 0 from that edge on.
REQ-032 Reset asserted during LOAD SHALL abandon the load without writing wb_*. A store presented in the same cycle as reset SHALL NOT write the RAM.

Structure
REQ-033 The f3 size codes, the rwsel codes and the FSM state encoding SHALL live in the shared CPU package.
REQ-034 The byte-enable RAM SHALL be a sub-module data_ram (parameter DEPTH_WORDS; ports clk, we[3:0], addr, wdata, rdata). The FSM, lane steering and the MEM/WB register SHALL stay in mem_stage.

Verification
REQ-035 SW 0xDEADBEEF to address 0x10, then LW from 0x10 with rd=5 -> stall high for exactly one cycle, then wb_rd=5, wb_data=0xDEADBEEF, wb_regwrite=1.
REQ-036 SB 0x80 to address 0x13, then LB and LBU from 0x13 -> wb_data=0xFFFFFF80, then 0x00000080; bytes 0x10..0x12 are unchanged.
REQ-037 SH to address 0x21 -> misaligned=1 for one cycle, wb_regwrite=0, and a subsequent LW from 0x20 returns the prior contents.
REQ-038 rwsel=01, pc_four=0x44, regwrite=1, rd=1, no memory access -> next edge gives wb_data=0x44, wb_rd=1, stall=0.
REQ-039 Assert reset in the LOAD state -> at the next edge stall=0 and wb_*=0, and the following ALU op completes normally.
REQ-040 LW from 0x410 with DEPTH_WORDS=256 -> returns the word at 0x010 (wrap-around).
